modcomb_seq: RTL

MODCOMB_SEQ -- requirements
Module: modcomb_seq

---
 rtl/modcomb_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/modcomb_seq.sv
// modcomb_seq: streams L operand pairs out of two banks, runs each pair
// through an external modular add/sub combiner, and writes sum/difference
// back in place (sum to bank A, difference to bank B).
//
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   start, len, base_a,       launch request and run descriptor
//   base_b, q_i               (sampled only while idle)
//   busy, done                run in progress / one-cycle completion pulse
//   rd_en, rd_addr_a/b        bank read strobe and addresses (1-cycle data)
//   rd_data_a/b               bank read data
//   mc_sel, mc_in0/1, mc_q    combiner op (0=add, 1=sub), operands, modulus
//   mc_out                    combiner result (2-cycle latency)
//   wr_en, wr_addr, wr_data   bank write strobe, address, data (= mc_out)

`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module modcomb_seq #(
    parameter int ADDR_W = 10,
    parameter int W      = `DATA_SIZE_ARB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [W-1:0]      q_i,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [W-1:0]      rd_data_a,
    input  logic [W-1:0]      rd_data_b,
    output logic              mc_sel,
    output logic [W-1:0]      mc_in0,
    output logic [W-1:0]      mc_in1,
    output logic [W-1:0]      mc_q,
    input  logic [W-1:0]      mc_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [W-1:0]      wr_data
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    // Reads still to issue after the one currently on the bus.
    logic [ADDR_W:0] cnt;

    // Per-stage valid bits, one stage per cycle after the read strobe:
    //   v1: read data on the bus, captured into the operand registers
    //   v2: combiner sees the add request
    //   v3: combiner sees the sub request
    //   v4: sum is being written
    logic v1;
    logic v2;
    logic v3;
    logic v4;

    // Address tags travel with the valid bits so write addresses never
    // depend on the read counters.
    logic [ADDR_W-1:0] tag_a1;
    logic [ADDR_W-1:0] tag_a2;
    logic [ADDR_W-1:0] tag_a3;
    logic [ADDR_W-1:0] tag_b1;
    logic [ADDR_W-1:0] tag_b2;
    logic [ADDR_W-1:0] tag_b3;
    logic [ADDR_W-1:0] tag_b4;

    // High while the current write is the difference (bank B) write.
    logic wr_b;

    // The final difference write is on the bus and nothing is behind it.
    logic last_wr;

    assign last_wr = wr_en & wr_b & ~rd_en & ~v1 & ~v2 & ~v3 & ~v4;

    assign wr_data = mc_out;

    // ------------------------------------------------------------------
    // Datapath pipeline: valid bits, tags, operand and write registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            v4      <= 1'b0;
            tag_a1  <= '0;
            tag_a2  <= '0;
            tag_a3  <= '0;
            tag_b1  <= '0;
            tag_b2  <= '0;
            tag_b3  <= '0;
            tag_b4  <= '0;
            mc_in0  <= '0;
            mc_in1  <= '0;
            mc_sel  <= 1'b0;
            wr_en   <= 1'b0;
            wr_b    <= 1'b0;
            wr_addr <= '0;
        end else begin
            v1     <= rd_en;
            v2     <= v1;
            v3     <= v2;
            v4     <= v3;
            tag_a1 <= rd_addr_a;
            tag_b1 <= rd_addr_b;
            tag_a2 <= tag_a1;
            tag_b2 <= tag_b1;
            tag_a3 <= tag_a2;
            tag_b3 <= tag_b2;
            tag_b4 <= tag_b3;

            // Operands stay put outside active cycles.
            if (v1) begin
                mc_in0 <= rd_data_a;
                mc_in1 <= rd_data_b;
            end

            // Add request in the v2 cycle (mc_sel=0), sub one cycle later.
            mc_sel <= v2;

            // Results come back two cycles after each request.
            wr_en <= v3 | v4;
            wr_b  <= v4;
            if (v3) begin
                wr_addr <= tag_a3;
            end else if (v4) begin
                wr_addr <= tag_b4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: read issue, completion and handshake outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            mc_q      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        mc_q      <= q_i;
                        rd_addr_a <= base_a;
                        rd_addr_b <= base_b;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            rd_en <= 1'b1;
                            cnt   <= len - (ADDR_W+1)'(1);
                        end
                    end
                end
                RUN: begin
                    // Reads alternate with idle cycles so each pair's
                    // operands hold for both combiner requests.
                    if (rd_en) begin
                        rd_en <= 1'b0;
                        if (cnt == '0) begin
                            state <= DRAIN;
                        end
                    end else begin
                        rd_en     <= 1'b1;
                        cnt       <= cnt - (ADDR_W+1)'(1);
                        rd_addr_a <= rd_addr_a + ADDR_W'(1);
                        rd_addr_b <= rd_addr_b + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (last_wr) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
